// File: rtl/exit_ctrl_pkg.sv
// exit_ctrl_pkg: shared constants and types for the simulation exit region.
//   - register offsets inside the region (ExitOff, DoneOff, IdOff, TimeoutOff)
//   - ExitCtrlId, the read-only identification word
//   - resp_t AXI response encodings, write/read FSM state enums
//   - reg_sel_e, the decoded register selector produced by exit_ctrl_addr_dec
//   - exit_word(), packing of the EXIT register read value
package exit_ctrl_pkg;

  localparam logic [11:0] ExitOff    = 12'h000;
  localparam logic [11:0] DoneOff    = 12'h008;
  localparam logic [11:0] IdOff      = 12'h100;
  localparam logic [11:0] TimeoutOff = 12'h108;

  localparam logic [63:0] ExitCtrlId = 64'h0000_0000_E417_C0DE;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_e;

  typedef enum logic [2:0] {
    SEL_NONE    = 3'd0,
    SEL_EXIT    = 3'd1,
    SEL_DONE    = 3'd2,
    SEL_ID      = 3'd3,
    SEL_TIMEOUT = 3'd4
  } reg_sel_e;

  // EXIT register layout: {32'b0, exit_code[30:0], exit_valid}
  function automatic logic [63:0] exit_word(input logic valid, input logic [30:0] code);
    return {32'h0000_0000, code, valid};
  endfunction

endpackage

// File: rtl/exit_ctrl_addr_dec.sv
// exit_ctrl_addr_dec: combinational address decoder for the exit region,
// used by both the write (AW) and the read (AR) paths.
// Ports:
//   addr  in  AddrWidth  byte address; bits [2:0] do not affect the decode
//   sel   out reg_sel_e  selected register, SEL_NONE on a miss or hole
//   idx   out 2          hart index when sel == SEL_DONE, 0 otherwise
// The counter register (TimeoutOff) is only decoded when TimeoutEn is set.
module exit_ctrl_addr_dec
  import exit_ctrl_pkg::*;
#(
  parameter int unsigned AddrWidth    = 64,
  parameter logic [63:0] BaseAddr     = 64'h0000_0000_8000_1000,
  parameter logic [63:0] RegionLength = 64'h0000_0000_0000_1000,
  parameter int unsigned NbHarts      = 2,
  parameter bit          TimeoutEn    = 1'b0
) (
  input  logic [AddrWidth-1:0] addr,
  output reg_sel_e             sel,
  output logic [1:0]           idx
);

  localparam logic [AddrWidth-1:0] Base    = BaseAddr[AddrWidth-1:0];
  localparam logic [AddrWidth-1:0] Len     = RegionLength[AddrWidth-1:0];
  localparam logic [AddrWidth-1:0] ExitW   = AddrWidth'(ExitOff);
  localparam logic [AddrWidth-1:0] DoneLoW = AddrWidth'(DoneOff);
  localparam logic [AddrWidth-1:0] DoneHiW = AddrWidth'(DoneOff) + AddrWidth'(32'd8 * NbHarts);
  localparam logic [AddrWidth-1:0] IdW     = AddrWidth'(IdOff);
  localparam logic [AddrWidth-1:0] TmoW    = AddrWidth'(TimeoutOff);

  logic [AddrWidth-1:0] offset_s;
  logic [AddrWidth-1:0] word_s;
  logic                 hit_s;

  assign offset_s = addr - Base;
  assign word_s   = {offset_s[AddrWidth-1:3], 3'b000};
  // Checking addr >= Base first keeps the wrapped offset of a low address
  // from looking like an in-range hit.
  assign hit_s    = (addr >= Base) && (offset_s < Len);

  // Map the in-region word offset onto a register selector and hart index.
  always_comb begin
    sel = SEL_NONE;
    idx = 2'd0;
    if (!hit_s) begin
      sel = SEL_NONE;
    end else if (word_s == ExitW) begin
      sel = SEL_EXIT;
    end else if ((word_s >= DoneLoW) && (word_s < DoneHiW)) begin
      sel = SEL_DONE;
      // DONE[h] sits at 8 + 8*h, so h is the word number minus one.
      idx = offset_s[4:3] - 2'd1;
    end else if (word_s == IdW) begin
      sel = SEL_ID;
    end else if (TimeoutEn && (word_s == TmoW)) begin
      sel = SEL_TIMEOUT;
    end else begin
      sel = SEL_NONE;
    end
  end

endmodule

// File: rtl/exit_ctrl_slave.sv
// exit_ctrl_slave: AXI4-Lite responder for the simulation exit region.
// Software writes the EXIT word (bit0 = 1, code in [31:1]) and per-hart DONE
// words; the block drives sticky exit/done status towards the testbench.
// Ports:
//   clk_i, rst_i                         clock, synchronous active-high reset
//   aw_*/w_*/b_*                         AXI4-Lite write address/data/response
//   ar_*/r_*                             AXI4-Lite read address/data
//   exit_valid_o, exit_code_o            sticky exit flag and 31-bit code
//   hart_done_o                          per-hart done flags
//   all_done_o                           AND of hart_done_o (combinational)
// Optional feature, macro EXIT_CTRL_TIMEOUT_EN: a saturating cycle counter
// forces exit with code 0xDEAD after TimeoutCycles and is readable at 0x108.
module exit_ctrl_slave
  import exit_ctrl_pkg::*;
#(
  parameter int unsigned AddrWidth     = 64,
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned NbHarts       = 2,
  parameter logic [63:0] BaseAddr      = 64'h0000_0000_8000_1000,
  parameter logic [63:0] RegionLength  = 64'h0000_0000_0000_1000,
  parameter logic [31:0] TimeoutCycles = 32'd1_000_000
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   aw_valid_i,
  output logic                   aw_ready_o,
  input  logic [AddrWidth-1:0]   aw_addr_i,
  input  logic                   w_valid_i,
  output logic                   w_ready_o,
  input  logic [DataWidth-1:0]   w_data_i,
  input  logic [DataWidth/8-1:0] w_strb_i,
  output logic                   b_valid_o,
  input  logic                   b_ready_i,
  output logic [1:0]             b_resp_o,
  input  logic                   ar_valid_i,
  output logic                   ar_ready_o,
  input  logic [AddrWidth-1:0]   ar_addr_i,
  output logic                   r_valid_o,
  input  logic                   r_ready_i,
  output logic [DataWidth-1:0]   r_data_o,
  output logic [1:0]             r_resp_o,
  output logic                   exit_valid_o,
  output logic [30:0]            exit_code_o,
  output logic [NbHarts-1:0]     hart_done_o,
  output logic                   all_done_o
);

  if (DataWidth != 32'd64) begin : g_dw_chk
    $error("exit_ctrl_slave: DataWidth must be 64");
  end
  if ((NbHarts < 32'd1) || (NbHarts > 32'd4)) begin : g_nh_chk
    $error("exit_ctrl_slave: NbHarts must be in 1..4");
  end
  if (TimeoutCycles == 32'd0) begin : g_tmo_chk
    $error("exit_ctrl_slave: TimeoutCycles must be nonzero");
  end

  wr_state_e            wstate_r;
  rd_state_e            rstate_r;
  logic                 aw_held_r;
  logic [AddrWidth-1:0] aw_addr_r;
  logic                 w_held_r;
  logic [31:0]          w_data_r;
  logic                 w_strb0_r;
  logic                 aw_ready_r;
  logic                 w_ready_r;
  logic                 b_valid_r;
  resp_t                b_resp_r;
  logic                 ar_ready_r;
  logic                 r_valid_r;
  logic [63:0]          r_data_r;
  resp_t                r_resp_r;
  logic                 exit_valid_r;
  logic [30:0]          exit_code_r;
  logic [NbHarts-1:0]   done_r;

  logic                 aw_hs_s;
  logic                 w_hs_s;
  logic                 ar_hs_s;
  logic                 aw_have_s;
  logic                 w_have_s;
  logic                 commit_s;
  logic [AddrWidth-1:0] wr_addr_s;
  logic [31:0]          wr_data_s;
  logic                 wr_strb0_s;
  reg_sel_e             wr_sel_s;
  logic [1:0]           wr_idx_s;
  resp_t                wr_resp_s;
  logic                 exit_set_s;
  reg_sel_e             rd_sel_s;
  logic [1:0]           rd_idx_s;
  logic                 rd_done_bit_s;
  logic [63:0]          rd_data_s;
  resp_t                rd_resp_s;
  logic                 tmo_fire_s;
  logic [31:0]          tmo_cnt_s;
  logic                 unused_bits_s;

`ifdef EXIT_CTRL_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;

  logic [31:0] tmo_cnt_r;
  logic [31:0] tmo_inc_s;

  assign tmo_inc_s  = (tmo_cnt_r == 32'hFFFF_FFFF) ? tmo_cnt_r : (tmo_cnt_r + 32'd1);
  assign tmo_fire_s = !exit_valid_r && (tmo_inc_s >= TimeoutCycles);
  assign tmo_cnt_s  = tmo_cnt_r;

  // Watchdog: count cycles until the test has exited, then freeze.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt_r <= 32'd0;
    end else if (!exit_valid_r) begin
      tmo_cnt_r <= tmo_inc_s;
    end
  end
`else
  localparam bit TimeoutEn = 1'b0;

  assign tmo_fire_s = 1'b0;
  assign tmo_cnt_s  = 32'd0;
`endif

  // Only the low data word and byte 0's strobe carry meaning in this map.
  assign unused_bits_s = ^{w_data_i[DataWidth-1:32], w_strb_i[DataWidth/8-1:1]};

  assign aw_hs_s = aw_valid_i && aw_ready_r;
  assign w_hs_s  = w_valid_i && w_ready_r;
  assign ar_hs_s = ar_valid_i && ar_ready_r;

  // A channel counts as present if held earlier or handshaking right now,
  // so the write commits on the edge of the later handshake.
  assign aw_have_s  = aw_held_r || aw_hs_s;
  assign w_have_s   = w_held_r || w_hs_s;
  assign commit_s   = (wstate_r == W_IDLE) && aw_have_s && w_have_s;
  assign wr_addr_s  = aw_held_r ? aw_addr_r : aw_addr_i;
  assign wr_data_s  = w_held_r ? w_data_r : w_data_i[31:0];
  assign wr_strb0_s = w_held_r ? w_strb0_r : w_strb_i[0];

  exit_ctrl_addr_dec #(
    .AddrWidth    (AddrWidth),
    .BaseAddr     (BaseAddr),
    .RegionLength (RegionLength),
    .NbHarts      (NbHarts),
    .TimeoutEn    (TimeoutEn)
  ) u_wr_dec (
    .addr (wr_addr_s),
    .sel  (wr_sel_s),
    .idx  (wr_idx_s)
  );

  exit_ctrl_addr_dec #(
    .AddrWidth    (AddrWidth),
    .BaseAddr     (BaseAddr),
    .RegionLength (RegionLength),
    .NbHarts      (NbHarts),
    .TimeoutEn    (TimeoutEn)
  ) u_rd_dec (
    .addr (ar_addr_i),
    .sel  (rd_sel_s),
    .idx  (rd_idx_s)
  );

  // Only EXIT and DONE are writable; ID, the counter and holes are errors.
  always_comb begin
    wr_resp_s = RESP_SLVERR;
    case (wr_sel_s)
      SEL_EXIT: wr_resp_s = RESP_OKAY;
      SEL_DONE: wr_resp_s = RESP_OKAY;
      default:  wr_resp_s = RESP_SLVERR;
    endcase
  end

  assign exit_set_s = commit_s && (wr_sel_s == SEL_EXIT) && wr_strb0_s &&
                      wr_data_s[0] && !exit_valid_r;

  // Pick the addressed done bit without a variable-width index.
  always_comb begin
    rd_done_bit_s = 1'b0;
    for (int h = 0; h < NbHarts; h++) begin
      rd_done_bit_s = (rd_idx_s == 2'(h)) ? done_r[h] : rd_done_bit_s;
    end
  end

  // Read data mux from the current (pre-write) register values.
  always_comb begin
    rd_data_s = 64'd0;
    rd_resp_s = RESP_SLVERR;
    case (rd_sel_s)
      SEL_EXIT: begin
        rd_data_s = exit_word(exit_valid_r, exit_code_r);
        rd_resp_s = RESP_OKAY;
      end
      SEL_DONE: begin
        rd_data_s = {63'd0, rd_done_bit_s};
        rd_resp_s = RESP_OKAY;
      end
      SEL_ID: begin
        rd_data_s = ExitCtrlId;
        rd_resp_s = RESP_OKAY;
      end
      SEL_TIMEOUT: begin
        rd_data_s = {32'd0, tmo_cnt_s};
        rd_resp_s = RESP_OKAY;
      end
      default: begin
        rd_data_s = 64'd0;
        rd_resp_s = RESP_SLVERR;
      end
    endcase
  end

  // Write FSM: latch AW/W independently, commit, hold B until accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wstate_r   <= W_IDLE;
      aw_held_r  <= 1'b0;
      aw_addr_r  <= '0;
      w_held_r   <= 1'b0;
      w_data_r   <= 32'd0;
      w_strb0_r  <= 1'b0;
      aw_ready_r <= 1'b0;
      w_ready_r  <= 1'b0;
      b_valid_r  <= 1'b0;
      b_resp_r   <= RESP_OKAY;
    end else begin
      case (wstate_r)
        W_IDLE: begin
          if (aw_hs_s) begin
            aw_held_r <= 1'b1;
            aw_addr_r <= aw_addr_i;
          end
          if (w_hs_s) begin
            w_held_r  <= 1'b1;
            w_data_r  <= w_data_i[31:0];
            w_strb0_r <= w_strb_i[0];
          end
          if (commit_s) begin
            wstate_r   <= W_RESP;
            b_valid_r  <= 1'b1;
            b_resp_r   <= wr_resp_s;
            aw_ready_r <= 1'b0;
            w_ready_r  <= 1'b0;
          end else begin
            aw_ready_r <= !aw_have_s;
            w_ready_r  <= !w_have_s;
          end
        end
        W_RESP: begin
          if (b_ready_i) begin
            wstate_r   <= W_IDLE;
            b_valid_r  <= 1'b0;
            aw_held_r  <= 1'b0;
            w_held_r   <= 1'b0;
            aw_ready_r <= 1'b1;
            w_ready_r  <= 1'b1;
          end
        end
        default: begin
          wstate_r   <= W_IDLE;
          b_valid_r  <= 1'b0;
          aw_held_r  <= 1'b0;
          w_held_r   <= 1'b0;
          aw_ready_r <= 1'b0;
          w_ready_r  <= 1'b0;
        end
      endcase
    end
  end

  // Read FSM: capture data on the AR handshake, hold R until accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rstate_r   <= R_IDLE;
      ar_ready_r <= 1'b0;
      r_valid_r  <= 1'b0;
      r_data_r   <= 64'd0;
      r_resp_r   <= RESP_OKAY;
    end else begin
      case (rstate_r)
        R_IDLE: begin
          if (ar_hs_s) begin
            rstate_r   <= R_RESP;
            ar_ready_r <= 1'b0;
            r_valid_r  <= 1'b1;
            r_data_r   <= rd_data_s;
            r_resp_r   <= rd_resp_s;
          end else begin
            ar_ready_r <= 1'b1;
          end
        end
        R_RESP: begin
          if (r_ready_i) begin
            rstate_r   <= R_IDLE;
            ar_ready_r <= 1'b1;
            r_valid_r  <= 1'b0;
          end
        end
        default: begin
          rstate_r   <= R_IDLE;
          ar_ready_r <= 1'b0;
          r_valid_r  <= 1'b0;
        end
      endcase
    end
  end

  // Status registers: sticky exit (watchdog wins a tie) and per-hart done.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exit_valid_r <= 1'b0;
      exit_code_r  <= 31'd0;
      done_r       <= '0;
    end else begin
      if (tmo_fire_s) begin
        exit_valid_r <= 1'b1;
        exit_code_r  <= 31'h0000_DEAD;
      end else if (exit_set_s) begin
        exit_valid_r <= 1'b1;
        exit_code_r  <= wr_data_s[31:1];
      end
      for (int h = 0; h < NbHarts; h++) begin
        if (commit_s && (wr_sel_s == SEL_DONE) && wr_strb0_s && (wr_idx_s == 2'(h))) begin
          done_r[h] <= wr_data_s[0];
        end
      end
    end
  end

  assign aw_ready_o   = aw_ready_r;
  assign w_ready_o    = w_ready_r;
  assign b_valid_o    = b_valid_r;
  assign b_resp_o     = b_resp_r;
  assign ar_ready_o   = ar_ready_r;
  assign r_valid_o    = r_valid_r;
  assign r_data_o     = r_data_r;
  assign r_resp_o     = r_resp_r;
  assign exit_valid_o = exit_valid_r;
  assign exit_code_o  = exit_code_r;
  assign hart_done_o  = done_r;
  assign all_done_o   = &done_r;

endmodule

// File: tb/tb_exit_ctrl_slave.sv
// tb_exit_ctrl_slave: directed, table-driven bench for exit_ctrl_slave
// (NbHarts = 2, BaseAddr = 0x8000_1000, TimeoutCycles = 100), plus
// hand-written sequences for out-of-order channels, B back-pressure,
// read/write collision, mid-flight reset and, under EXIT_CTRL_TIMEOUT_EN,
// the watchdog.
module tb_exit_ctrl_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        aw_valid = 1'b0;
  logic        aw_ready;
  logic [63:0] aw_addr = 64'd0;
  logic        w_valid = 1'b0;
  logic        w_ready;
  logic [63:0] w_data = 64'd0;
  logic [7:0]  w_strb = 8'd0;
  logic        b_valid;
  logic        b_ready = 1'b0;
  logic [1:0]  b_resp;
  logic        ar_valid = 1'b0;
  logic        ar_ready;
  logic [63:0] ar_addr = 64'd0;
  logic        r_valid;
  logic        r_ready = 1'b0;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        exit_valid;
  logic [30:0] exit_code;
  logic [1:0]  hart_done;
  logic        all_done;

  int checks = 0;
  int failures = 0;

  exit_ctrl_slave #(
    .AddrWidth     (64),
    .DataWidth     (64),
    .NbHarts       (2),
    .BaseAddr      (64'h0000_0000_8000_1000),
    .RegionLength  (64'h0000_0000_0000_1000),
    .TimeoutCycles (32'd100)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .aw_valid_i   (aw_valid),
    .aw_ready_o   (aw_ready),
    .aw_addr_i    (aw_addr),
    .w_valid_i    (w_valid),
    .w_ready_o    (w_ready),
    .w_data_i     (w_data),
    .w_strb_i     (w_strb),
    .b_valid_o    (b_valid),
    .b_ready_i    (b_ready),
    .b_resp_o     (b_resp),
    .ar_valid_i   (ar_valid),
    .ar_ready_o   (ar_ready),
    .ar_addr_i    (ar_addr),
    .r_valid_o    (r_valid),
    .r_ready_i    (r_ready),
    .r_data_o     (r_data),
    .r_resp_o     (r_resp),
    .exit_valid_o (exit_valid),
    .exit_code_o  (exit_code),
    .hart_done_o  (hart_done),
    .all_done_o   (all_done)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [1:0]  exp_resp;
    logic [63:0] exp_rdata;
    logic        exp_exit;
    logic [30:0] exp_code;
    logic [1:0]  exp_done;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic note_timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=response", name);
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb,
                          output logic [1:0] resp, output logic lat_ok);
    int n;
    @(negedge clk);
    aw_valid = 1'b1; aw_addr = addr; w_valid = 1'b1; w_data = data; w_strb = strb;
    n = 0;
    while (!(aw_ready && w_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      note_timeout("wr_ready_wait");
      aw_valid = 1'b0; w_valid = 1'b0; resp = 2'b11; lat_ok = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    aw_valid = 1'b0; w_valid = 1'b0;
    lat_ok = b_valid;
    n = 0;
    while (!b_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      note_timeout("b_valid_wait");
      resp = 2'b11;
      return;
    end
    resp = b_resp;
    b_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_ready = 1'b0;
  endtask

  task automatic do_read(input logic [63:0] addr, output logic [1:0] resp, output logic [63:0] data,
                         output logic lat_ok);
    int n;
    @(negedge clk);
    ar_valid = 1'b1; ar_addr = addr;
    n = 0;
    while (!ar_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      note_timeout("ar_ready_wait");
      ar_valid = 1'b0; resp = 2'b11; data = '1; lat_ok = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    ar_valid = 1'b0;
    lat_ok = r_valid;
    n = 0;
    while (!r_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      note_timeout("r_valid_wait");
      resp = 2'b11; data = '1;
      return;
    end
    resp = r_resp;
    data = r_data;
    r_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    r_ready = 1'b0;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [63:0] data;
    logic        lat;
    int          k;

    //             wr    addr                    data      strb   resp   rdata                   ex    code    done
    vecs[0]  = '{1'b1, 64'h0000_0000_8000_1000, 64'h6, 8'hFF, 2'b00, 64'h0,                   1'b0, 31'd0, 2'b01};
    vecs[1]  = '{1'b1, 64'h0000_0000_8000_1000, 64'h7, 8'h00, 2'b00, 64'h0,                   1'b0, 31'd0, 2'b01};
    vecs[2]  = '{1'b0, 64'h0000_0000_8000_1000, 64'h0, 8'h00, 2'b00, 64'h0,                   1'b0, 31'd0, 2'b01};
    vecs[3]  = '{1'b1, 64'h0000_0000_8000_1000, 64'h7, 8'hFF, 2'b00, 64'h0,                   1'b1, 31'd3, 2'b01};
    vecs[4]  = '{1'b1, 64'h0000_0000_8000_1000, 64'h9, 8'hFF, 2'b00, 64'h0,                   1'b1, 31'd3, 2'b01};
    vecs[5]  = '{1'b0, 64'h0000_0000_8000_1000, 64'h0, 8'h00, 2'b00, 64'h7,                   1'b1, 31'd3, 2'b01};
    vecs[6]  = '{1'b0, 64'h0000_0000_8000_1003, 64'h0, 8'h00, 2'b00, 64'h7,                   1'b1, 31'd3, 2'b01};
    vecs[7]  = '{1'b1, 64'h0000_0000_8000_1010, 64'h1, 8'hFF, 2'b00, 64'h0,                   1'b1, 31'd3, 2'b11};
    vecs[8]  = '{1'b0, 64'h0000_0000_8000_1010, 64'h0, 8'h00, 2'b00, 64'h1,                   1'b1, 31'd3, 2'b11};
    vecs[9]  = '{1'b1, 64'h0000_0000_8000_1010, 64'h0, 8'hFF, 2'b00, 64'h0,                   1'b1, 31'd3, 2'b01};
    vecs[10] = '{1'b1, 64'h0000_0000_8000_1010, 64'h1, 8'hFE, 2'b00, 64'h0,                   1'b1, 31'd3, 2'b01};
    vecs[11] = '{1'b0, 64'h0000_0000_8000_1100, 64'h0, 8'h00, 2'b00, 64'h0000_0000_E417_C0DE, 1'b1, 31'd3, 2'b01};
    vecs[12] = '{1'b0, 64'h0000_0000_8000_1200, 64'h0, 8'h00, 2'b10, 64'h0,                   1'b1, 31'd3, 2'b01};
    vecs[13] = '{1'b1, 64'h0000_0000_8000_1100, 64'h5, 8'hFF, 2'b10, 64'h0,                   1'b1, 31'd3, 2'b01};
    vecs[14] = '{1'b0, 64'h0000_0000_8000_1018, 64'h0, 8'h00, 2'b10, 64'h0,                   1'b1, 31'd3, 2'b01};
    vecs[15] = '{1'b1, 64'h0000_0000_8000_1018, 64'h1, 8'hFF, 2'b10, 64'h0,                   1'b1, 31'd3, 2'b01};
    vecs[16] = '{1'b0, 64'h0000_0000_8000_0FF8, 64'h0, 8'h00, 2'b10, 64'h0,                   1'b1, 31'd3, 2'b01};
    vecs[17] = '{1'b1, 64'h0000_0000_8000_2000, 64'h1, 8'hFF, 2'b10, 64'h0,                   1'b1, 31'd3, 2'b01};
    vecs[18] = '{1'b0, 64'h0000_0000_8000_1FF8, 64'h0, 8'h00, 2'b10, 64'h0,                   1'b1, 31'd3, 2'b01};
    vecs[19] = '{1'b0, 64'h0000_0000_8000_1008, 64'h0, 8'h00, 2'b00, 64'h1,                   1'b1, 31'd3, 2'b01};

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_aw_ready", {63'd0, aw_ready}, 64'd0);
    check("rst_w_ready", {63'd0, w_ready}, 64'd0);
    check("rst_ar_ready", {63'd0, ar_ready}, 64'd0);
    check("rst_b_valid", {63'd0, b_valid}, 64'd0);
    check("rst_r_valid", {63'd0, r_valid}, 64'd0);
    check("rst_exit", {63'd0, exit_valid}, 64'd0);
    check("rst_code", {33'd0, exit_code}, 64'd0);
    check("rst_done", {62'd0, hart_done}, 64'd0);
    check("rst_all_done", {63'd0, all_done}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_aw_ready", {63'd0, aw_ready}, 64'd1);
    check("post_rst_w_ready", {63'd0, w_ready}, 64'd1);
    check("post_rst_ar_ready", {63'd0, ar_ready}, 64'd1);

    // ---------------- W before AW, then B back-pressure ----------------
    w_valid = 1'b1; w_data = 64'h1; w_strb = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    w_valid = 1'b0;
    check("ooo_w_ready_low", {63'd0, w_ready}, 64'd0);
    check("ooo_aw_ready_high", {63'd0, aw_ready}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("ooo_no_b_%0d", i), {63'd0, b_valid}, 64'd0);
      @(negedge clk);
    end
    aw_valid = 1'b1; aw_addr = 64'h0000_0000_8000_1008;
    @(posedge clk);
    @(negedge clk);
    aw_valid = 1'b0;
    check("ooo_b_valid", {63'd0, b_valid}, 64'd1);
    check("ooo_b_resp", {62'd0, b_resp}, 64'd0);
    check("ooo_done", {62'd0, hart_done}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("bp_b_valid_%0d", i), {63'd0, b_valid}, 64'd1);
      check($sformatf("bp_b_resp_%0d", i), {62'd0, b_resp}, 64'd0);
      check($sformatf("bp_aw_ready_%0d", i), {63'd0, aw_ready}, 64'd0);
    end
    b_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_ready = 1'b0;
    check("bp_b_released", {63'd0, b_valid}, 64'd0);
    check("bp_aw_ready_back", {63'd0, aw_ready}, 64'd1);

    // ---------------- table of single transactions ----------------
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, lat);
        check($sformatf("v%0d_b_resp", i), {62'd0, resp}, {62'd0, vecs[i].exp_resp});
        check($sformatf("v%0d_b_latency", i), {63'd0, lat}, 64'd1);
      end else begin
        do_read(vecs[i].addr, resp, data, lat);
        check($sformatf("v%0d_r_resp", i), {62'd0, resp}, {62'd0, vecs[i].exp_resp});
        check($sformatf("v%0d_r_data", i), data, vecs[i].exp_rdata);
        check($sformatf("v%0d_r_latency", i), {63'd0, lat}, 64'd1);
      end
      check($sformatf("v%0d_exit", i), {63'd0, exit_valid}, {63'd0, vecs[i].exp_exit});
      check($sformatf("v%0d_code", i), {33'd0, exit_code}, {33'd0, vecs[i].exp_code});
      check($sformatf("v%0d_done", i), {62'd0, hart_done}, {62'd0, vecs[i].exp_done});
      check($sformatf("v%0d_all_done", i), {63'd0, all_done}, {63'd0, &vecs[i].exp_done});
    end

    // ---------------- read and write of DONE0 on the same edge ----------------
    @(negedge clk);
    aw_valid = 1'b1; aw_addr = 64'h0000_0000_8000_1008;
    w_valid = 1'b1; w_data = 64'h0; w_strb = 8'hFF;
    ar_valid = 1'b1; ar_addr = 64'h0000_0000_8000_1008;
    @(posedge clk);
    @(negedge clk);
    aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
    check("coll_b_valid", {63'd0, b_valid}, 64'd1);
    check("coll_r_valid", {63'd0, r_valid}, 64'd1);
    check("coll_old_data", r_data, 64'd1);
    check("coll_done_new", {62'd0, hart_done}, 64'd0);
    b_ready = 1'b1; r_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_ready = 1'b0; r_ready = 1'b0;
    check("coll_b_clear", {63'd0, b_valid}, 64'd0);
    check("coll_r_clear", {63'd0, r_valid}, 64'd0);
    do_read(64'h0000_0000_8000_1008, resp, data, lat);
    check("coll_reread", data, 64'd0);

    // ---------------- reset while a write response is pending ----------------
    @(negedge clk);
    aw_valid = 1'b1; aw_addr = 64'h0000_0000_8000_1010;
    w_valid = 1'b1; w_data = 64'h1; w_strb = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    aw_valid = 1'b0; w_valid = 1'b0;
    check("mid_b_pending", {63'd0, b_valid}, 64'd1);
    check("mid_done_pre", {62'd0, hart_done}, 64'd2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_b_dropped", {63'd0, b_valid}, 64'd0);
    check("mid_exit_clr", {63'd0, exit_valid}, 64'd0);
    check("mid_code_clr", {33'd0, exit_code}, 64'd0);
    check("mid_done_clr", {62'd0, hart_done}, 64'd0);
    check("mid_aw_ready_rst", {63'd0, aw_ready}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_aw_ready_back", {63'd0, aw_ready}, 64'd1);
    do_write(64'h0000_0000_8000_1000, 64'h3, 8'h01, resp, lat);
    check("mid_new_exit_resp", {62'd0, resp}, 64'd0);
    check("mid_new_exit", {63'd0, exit_valid}, 64'd1);
    check("mid_new_code", {33'd0, exit_code}, 64'd1);

`ifdef EXIT_CTRL_TIMEOUT_EN
    // ---------------- watchdog ----------------
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    while (k < 200) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (exit_valid) break;
    end
    check("tmo_cycle", 64'(k), 64'd100);
    check("tmo_code", {33'd0, exit_code}, 64'h0000_DEAD);
    do_write(64'h0000_0000_8000_1000, 64'h7, 8'hFF, resp, lat);
    check("tmo_sw_resp", {62'd0, resp}, 64'd0);
    check("tmo_sw_ignored", {33'd0, exit_code}, 64'h0000_DEAD);
    do_read(64'h0000_0000_8000_1108, resp, data, lat);
    check("tmo_cnt_resp", {62'd0, resp}, 64'd0);
    check("tmo_cnt_data", data, 64'd100);
`else
    k = 0;
    do_read(64'h0000_0000_8000_1108, resp, data, lat);
    check("cnt_absent_resp", {62'd0, resp}, 64'd2);
    check("cnt_absent_data", data, 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
